// File: rtl/sd_init_seq.sv
// SD card SPI-mode initialisation sequencer: dummy clocks, CMD0, optional CMD8, CMD1 or
// CMD55+ACMD41 polling, then DONE/ERROR. Define SD_CMD8_EN to include the CMD8 phase.
module sd_init_seq #(
   parameter int unsigned DUMMY_EDGES = 74,
   parameter int unsigned RETRY_MAX   = 255,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter logic [7:0]  SLOW_DIV    = 8'hFF,
   parameter logic [7:0]  FAST_DIV    = 8'h00,
   parameter int unsigned ACMD41_MODE = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       restart,
   output logic [6:0] cmd,
   output logic       SDctrl_start,
   output logic       en_clk,
   output logic [7:0] div_clk,
   output logic       cs,
   input  logic       sclk_fall,
   input  logic       SDctrl_valid_status,
   input  logic [6:0] SDctrl_status,
   input  logic       SDctrl_available,
   output logic       done,
   output logic       error,
   output logic [6:0] last_status
);

   localparam int unsigned DW = $clog2(DUMMY_EDGES) + 1;
   localparam int unsigned RW = $clog2(RETRY_MAX) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [DW-1:0] DUMMY_LAST = DW'(DUMMY_EDGES);
   localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      StDummy,
      StCmd0,
`ifdef SD_CMD8_EN
      StCmd8,
`endif
      StCmd55,
      StInit,
      StDone,
      StError
   } state_e;

   typedef enum logic {PhIssue, PhResp} phase_e;

   state_e          state_q, state_d, next_cmd, init_first;
   phase_e          phase_q, phase_d;
   logic [DW-1:0]   dummy_cnt_q, dummy_cnt_d;
   logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [6:0]      last_status_q, last_status_d;
   logic            reissue, next_phase, goto_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StDummy;
         phase_q       <= PhIssue;
         dummy_cnt_q   <= '0;
         retry_cnt_q   <= '0;
         tmo_cnt_q     <= '0;
         last_status_q <= 7'h00;
      end else begin
         state_q       <= state_d;
         phase_q       <= phase_d;
         dummy_cnt_q   <= dummy_cnt_d;
         retry_cnt_q   <= retry_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         last_status_q <= last_status_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      dummy_cnt_d   = dummy_cnt_q;
      retry_cnt_d   = retry_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;
      last_status_d = last_status_q;
      SDctrl_start  = 1'b0;
      reissue       = 1'b0;
      next_phase    = 1'b0;
      goto_err      = 1'b0;
      next_cmd      = state_q;
      init_first    = StInit;
      if (ACMD41_MODE != 0) init_first = StCmd55;

      case (state_q)
         StDummy: begin
            if (dummy_cnt_q == DUMMY_LAST) begin
               state_d     = StCmd0;
               phase_d     = PhIssue;
               dummy_cnt_d = '0;
               retry_cnt_d = '0;
            end else if (sclk_fall) begin
               dummy_cnt_d = dummy_cnt_q + 1'b1;
            end
         end
         StDone, StError: begin
            if (restart) begin
               state_d     = StDummy;
               phase_d     = PhIssue;
               dummy_cnt_d = '0;
               retry_cnt_d = '0;
               tmo_cnt_d   = '0;
            end
         end
         default: begin
            if (phase_q == PhIssue) begin
               tmo_cnt_d = '0;
               // Timeout window counts from the start-pulse cycle itself.
               if (SDctrl_available) begin
                  SDctrl_start = 1'b1;
                  phase_d      = PhResp;
                  tmo_cnt_d    = TW'(1);
               end
            end else if (SDctrl_valid_status) begin
               last_status_d = SDctrl_status;
               case (state_q)
                  StCmd0: begin
                     if (SDctrl_status == 7'h01) begin
                        next_phase = 1'b1;
`ifdef SD_CMD8_EN
                        next_cmd   = StCmd8;
`else
                        next_cmd   = init_first;
`endif
                     end else begin
                        reissue = 1'b1;
                     end
                  end
`ifdef SD_CMD8_EN
                  StCmd8: begin
                     if (SDctrl_status == 7'h01 || SDctrl_status == 7'h05) begin
                        next_phase = 1'b1;
                        next_cmd   = init_first;
                     end else begin
                        goto_err = 1'b1;
                     end
                  end
`endif
                  StCmd55: begin
                     if (SDctrl_status == 7'h00 || SDctrl_status == 7'h01) begin
                        state_d = StInit;
                        phase_d = PhIssue;
                     end else begin
                        goto_err = 1'b1;
                     end
                  end
                  default: begin
                     if (SDctrl_status == 7'h00) begin
                        state_d = StDone;
                        phase_d = PhIssue;
                     end else if (SDctrl_status == 7'h01) begin
                        reissue = 1'b1;
                     end else begin
                        goto_err = 1'b1;
                     end
                  end
               endcase
            end else if (tmo_cnt_q >= TMO_LAST) begin
               reissue = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
      endcase

      if (next_phase) begin
         state_d     = next_cmd;
         phase_d     = PhIssue;
         retry_cnt_d = '0;
      end
      if (reissue) begin
         if (retry_cnt_q == RETRY_LAST) begin
            goto_err = 1'b1;
         end else begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            phase_d     = PhIssue;
            // ACMD41 must always be preceded by a fresh CMD55.
            if (state_q == StInit && ACMD41_MODE != 0) state_d = StCmd55;
            else state_d = state_q;
         end
      end
      if (goto_err) begin
         state_d = StError;
         phase_d = PhIssue;
      end
   end

   always_comb begin
      cmd     = 7'h00;
      cs      = 1'b0;
      div_clk = SLOW_DIV;
      done    = 1'b0;
      error   = 1'b0;
      case (state_q)
         StDummy: cs = 1'b1;
`ifdef SD_CMD8_EN
         StCmd8:  cmd = 7'h08;
`endif
         StCmd55: cmd = 7'h37;
         StInit:  cmd = (ACMD41_MODE != 0) ? 7'h29 : 7'h01;
         StDone: begin
            done    = 1'b1;
            div_clk = FAST_DIV;
         end
         StError: begin
            error = 1'b1;
            cs    = 1'b1;
         end
         default: cmd = 7'h00;
      endcase
   end

   assign en_clk      = 1'b1;
   assign last_status = last_status_q;

endmodule

// File: doc/sd_init_seq.md
SD_INIT_SEQ -- requirements
Module: sd_init_seq

Interface
REQ-001 The block SHALL have parameter DUMMY_EDGES, default 74, meaning the number of sclk falling edges with cs high before CMD0.
REQ-002 The block SHALL have parameter RETRY_MAX, default 255, meaning the maximum number of re-issues per init phase before ERROR.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 4096, meaning the clk cycles allowed from start pulse to valid status.
REQ-004 The block SHALL have parameter SLOW_DIV, default 8'hFF, meaning the div_clk value used during initialisation.
REQ-005 The block SHALL have parameter FAST_DIV, default 8'h00, meaning the div_clk value used in DONE.
REQ-006 The block SHALL have parameter ACMD41_MODE, default 0, meaning 0 = CMD1 init and 1 = CMD55+ACMD41 init.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 The block SHALL have port restart, input, 1 bit: a one-cycle request to re-run init, honoured only in DONE or ERROR.
REQ-010 The block SHALL have outputs cmd (7 bits, command index), SDctrl_start (1 bit, command start pulse), en_clk (1 bit, constant 1), div_clk (8 bits) and cs (1 bit, card select, active-low).
REQ-011 The block SHALL have inputs sclk_fall, SDctrl_valid_status, SDctrl_status (7 bits, R1 response) and SDctrl_available, each 1 bit except SDctrl_status.
REQ-012 The block SHALL have outputs done (1 bit), error (1 bit) and last_status (7 bits, last captured R1).

Function
REQ-013 The FSM SHALL have states DUMMY, CMD0, CMD8, CMD55, INIT, DONE and ERROR, each command state having an ISSUE phase and a RESP phase.
REQ-014 In DUMMY, cs=1; the block SHALL count sclk_fall pulses, and on count==DUMMY_EDGES it SHALL set cs=0 and enter CMD0/ISSUE on the next cycle.
REQ-015 In ISSUE, the block SHALL pulse SDctrl_start for exactly one cycle in the first cycle with SDctrl_available=1, then enter RESP and clear the timeout counter.
REQ-016 In RESP, on SDctrl_valid_status=1 the block SHALL capture SDctrl_status into last_status and evaluate it in the same cycle.
REQ-017 SDctrl_valid_status outside a RESP phase SHALL be ignored, and last_status SHALL be unchanged.
REQ-018 In CMD0, the block SHALL go to the next command on status 7'h01; any other status or a timeout SHALL re-issue CMD0.
REQ-019 In INIT (cmd=7'h01, or 7'h29 when ACMD41_MODE=1), the block SHALL go to DONE on 7'h00, re-issue on 7'h01, and go to ERROR on any other value.
REQ-020 When ACMD41_MODE=1, each INIT issue SHALL be preceded by CMD55 (cmd=7'h37), and a CMD55 response other than 7'h00 or 7'h01 SHALL go to ERROR.
REQ-021 Each re-issue SHALL increment the phase retry counter, which is cleared on phase entry; a re-issue with counter==RETRY_MAX SHALL go to ERROR instead.
REQ-022 A timeout SHALL be declared when the RESP timeout counter reaches TIMEOUT_CYC-1 without valid status, and it SHALL be treated as a re-issue.
REQ-023 In DONE, outputs SHALL be done=1, cs=0, div_clk=FAST_DIV and cmd=7'h00; elsewhere div_clk=SLOW_DIV.
REQ-024 In ERROR, outputs SHALL be error=1 and cs=1, held until rst or restart.
REQ-025 restart in DONE or ERROR SHALL clear done, error and all counters and enter DUMMY with cs=1; restart in any other state SHALL be ignored.
REQ-026 If restart and SDctrl_valid_status occur in the same cycle, restart SHALL win.
REQ-027 Counter widths SHALL be $clog2 of their limit plus 1, so that no counter wraps before its compare value.

Reset
REQ-028 On rst=1 the block SHALL enter DUMMY with cs=1, SDctrl_start=0, done=0, error=0, last_status=7'h00, cmd=7'h00, div_clk=SLOW_DIV, en_clk=1 and all counters 0.
REQ-029 rst mid-command SHALL abort immediately, and a later valid status for the aborted command SHALL be ignored by REQ-017.

Configuration
REQ-030 With macro SD_CMD8_EN defined, a successful CMD0 SHALL go to CMD8 (cmd=7'h08), and in CMD8 status 7'h01 SHALL go to INIT (or CMD55), 7'h05 SHALL go to INIT, other values SHALL go to ERROR, and a timeout SHALL re-issue.
REQ-031 Without SD_CMD8_EN, the CMD8 state SHALL be absent and CMD0 success SHALL go directly to INIT (or CMD55).

Verification
REQ-032 The bench SHALL cover: DUMMY_EDGES=74 with 74 sclk_fall pulses -> cs falls and a single SDctrl_start with cmd=7'h00 follows.
REQ-033 The bench SHALL cover: CMD0 answered 7'h01, then INIT answered 7'h01 twice then 7'h00 -> exactly 3 INIT start pulses, then done=1 and div_clk=8'h00.
REQ-034 The bench SHALL cover: RETRY_MAX=3 with INIT always answered 7'h01 -> 4 INIT issues, then error=1 and cs=1.
REQ-035 The bench SHALL cover: TIMEOUT_CYC=16 with no valid status on CMD0 -> CMD0 re-issued 16 cycles after the start pulse, and last_status unchanged.
REQ-036 The bench SHALL cover: ACMD41_MODE=1 with SD_CMD8_EN defined -> cmd order 0x00, 0x08, 0x37, 0x29, and a 7'h04 response to CMD55 -> ERROR.
REQ-037 The bench SHALL cover: restart in ERROR coincident with SDctrl_valid_status -> DUMMY entered, error=0, and last_status unchanged.
